partoserial: RTL and testbench

Parallel-to-serial transmitter for the byte-serial link. It accepts 8-bit words with a valid/ready handshake and serializes them LSB-first on a single line, one bit per `clk_8f` cycle. It opens every reset with a run of `8'hBC` comma bytes so the far-end `serialtopar` can lock, and fills every byte slot that has no valid data with `8'hBC`. It sits at the transmit end of the link, between the parallel datapath and the serial wire.

---
 rtl/partoserial.sv | 48 ++++
 tb/tb_partoserial.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/partoserial.sv
// rtl/partoserial.sv - byte-serial transmitter, LSB first, with comma preamble and idle fill
module partoserial #(
  parameter int         PREAMBLE_BYTES = 4,
  parameter logic [7:0] IDLE_CHAR      = 8'hBC
) (
  input  logic       clk_8f,
  input  logic       reset_L,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       data_out,
  output logic       frame_out,
  output logic       active_out
);
  localparam logic [3:0] PRE_LAST = 4'(PREAMBLE_BYTES - 1);

  logic [2:0] phase;
  logic [7:0] shreg;
  logic [3:0] pre_cnt;
  logic       byte_end;

  assign byte_end  = (phase == 3'd7);
  // Only flop-derived terms, so the source may make valid_in depend on ready_out.
  assign ready_out = byte_end && (pre_cnt == PRE_LAST);
  assign frame_out = (phase == 3'd0);
  assign data_out  = shreg[0];

  always_ff @(posedge clk_8f or negedge reset_L) begin
    if (!reset_L) begin
      phase      <= 3'd0;
      shreg      <= IDLE_CHAR;
      pre_cnt    <= 4'd0;
      active_out <= 1'b0;
    end else begin
      phase <= phase + 3'd1;
      if (byte_end) begin
        shreg <= (ready_out && valid_in) ? data_in : IDLE_CHAR;
        if (pre_cnt != PRE_LAST) begin
          pre_cnt <= pre_cnt + 4'd1;
        end else begin
          active_out <= 1'b1;
        end
      end else begin
        shreg <= {1'b0, shreg[7:1]};
      end
    end
  end
endmodule

// File: tb/tb_partoserial.sv
// tb/tb_partoserial.sv - scoreboard bench for partoserial: preamble, handshake, reset and loopback
module tb_partoserial;
  logic       clk_8f = 1'b0;
  logic       reset_L;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out;
  logic       data_out;
  logic       frame_out;
  logic       active_out;

  typedef struct {
    int         cyc;
    logic       v;
    logic [7:0] d;
  } stim_t;

  stim_t      stim[$];
  logic [7:0] exp_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         cur_cyc  = 0;
  logic [7:0] rx;
  logic [3:0] bit_cnt = 4'd0;

  partoserial #(.PREAMBLE_BYTES(4), .IDLE_CHAR(8'hBC)) dut (
    .clk_8f    (clk_8f),
    .reset_L   (reset_L),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .data_out  (data_out),
    .frame_out (frame_out),
    .active_out(active_out)
  );

  always #5 clk_8f = ~clk_8f;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cur_cyc, act, req);
    end
  endtask

  // Receiver model: assemble LSB-first bytes aligned to frame_out and score them.
  always @(negedge clk_8f) begin
    if (!reset_L) begin
      bit_cnt = 4'd0;
    end else begin
      if (frame_out) bit_cnt = 4'd0;
      rx[bit_cnt[2:0]] = data_out;
      bit_cnt = bit_cnt + 4'd1;
      if (bit_cnt == 4'd8) begin
        bit_cnt = 4'd0;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL byte_underflow cycle %0d: got %h expected no byte", cur_cyc, rx);
        end else begin
          check("byte", rx, exp_q.pop_front());
        end
      end
    end
  end

  task automatic do_reset();
    valid_in = 1'b0;
    data_in  = 8'h00;
    reset_L  = 1'b0;
    repeat (2) @(posedge clk_8f);
    #2 reset_L = 1'b1;
  endtask

  task automatic push_preamble();
    repeat (4) exp_q.push_back(8'hBC);
  endtask

  task automatic run(input int ncyc, input int reset_at);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk_8f);
      cur_cyc = c;
      check("ready", {7'd0, ready_out}, {7'd0, (c >= 31) && (c % 8 == 7)});
      check("active", {7'd0, active_out}, {7'd0, c >= 32});
      check("frame", {7'd0, frame_out}, {7'd0, c % 8 == 0});
      foreach (stim[i]) begin
        if (stim[i].cyc == c) begin
          valid_in = stim[i].v;
          data_in  = stim[i].d;
        end
      end
      if (c == reset_at) begin
        check("pending_bytes", 8'(exp_q.size()), 8'd1);
        #2 reset_L = 1'b0;
        #1;
        check("rst_data", {7'd0, data_out}, 8'd0);
        check("rst_frame", {7'd0, frame_out}, 8'd1);
        check("rst_ready", {7'd0, ready_out}, 8'd0);
        check("rst_active", {7'd0, active_out}, 8'd0);
        exp_q.delete();
        return;
      end
    end
    @(posedge clk_8f);
    #1 check("drain", 8'(exp_q.size()), 8'd0);
  endtask

  initial begin
    reset_L  = 1'b0;
    valid_in = 1'b0;
    data_in  = 8'h00;
    #1;
    check("init_data", {7'd0, data_out}, 8'd0);
    check("init_frame", {7'd0, frame_out}, 8'd1);
    check("init_ready", {7'd0, ready_out}, 8'd0);
    check("init_active", {7'd0, active_out}, 8'd0);

    // Single word held from cycle 20, ignored pulse at 34, then back-to-back 01 02 FF.
    push_preamble();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'hBC);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hBC);
    exp_q.push_back(8'hBC);
    stim.push_back('{20, 1'b1, 8'hA5});
    stim.push_back('{32, 1'b0, 8'hA5});
    stim.push_back('{34, 1'b1, 8'h3C});
    stim.push_back('{35, 1'b0, 8'h3C});
    stim.push_back('{47, 1'b1, 8'h01});
    stim.push_back('{48, 1'b1, 8'h02});
    stim.push_back('{56, 1'b1, 8'hFF});
    stim.push_back('{64, 1'b0, 8'h00});
    do_reset();
    run(88, -1);

    // Reset in the middle of an A5 byte.
    stim.delete();
    push_preamble();
    exp_q.push_back(8'hA5);
    stim.push_back('{0, 1'b1, 8'hA5});
    do_reset();
    run(40, 35);
    repeat (3) @(negedge clk_8f);
    check("hold_frame", {7'd0, frame_out}, 8'd1);
    check("hold_data", {7'd0, data_out}, 8'd0);

    // Loopback of 00..0F, valid held high through the preamble.
    stim.delete();
    push_preamble();
    for (int k = 0; k < 16; k++) exp_q.push_back(8'(k));
    exp_q.push_back(8'hBC);
    exp_q.push_back(8'hBC);
    stim.push_back('{0, 1'b1, 8'h00});
    for (int k = 1; k < 16; k++) stim.push_back('{24 + 8 * k, 1'b1, 8'(k)});
    stim.push_back('{152, 1'b0, 8'h00});
    do_reset();
    run(176, -1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
